// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data RAM between two requesters: the processor
// load/store path (port C) and a debug/DMA loader (port D). One request is
// captured at a time. Each captured request then runs a fixed three-state
// access (IDLE -> ACCESS -> DONE). The owner receives a one-cycle
// acknowledge together with registered read data and an error flag.
// While the processor's access is outstanding, it is stalled so that the PC
// and register write-back stay frozen.
//
// Optional feature (compile-time macro):
//   DMEM_ARB_FIXED_PRIO_EN - when defined, C always wins simultaneous
//                            requests and no round-robin state exists
//                            (D can be starved). When undefined, ties are
//                            broken round-robin.
//
// Parameters:
//   DATA_WIDTH   - width of all data buses
//   ADDR_WIDTH   - width of requester byte addresses and the RAM address
//   MEM_BASE     - byte address of RAM word 0
//   MEMORY_DEPTH - RAM depth in words
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_c_req       processor request, held until o_c_ack
//   i_c_we        processor store (1) / load (0)
//   i_c_addr      processor byte address
//   i_c_wdata     processor store data
//   o_c_ack       one-cycle access-complete pulse
//   o_c_rdata     registered load data, valid while o_c_ack is high
//   o_c_err       pulses with o_c_ack for an illegal access
//   o_c_stall     i_c_req & ~o_c_ack
//   i_d_* / o_d_* same as the C port, for the debug/DMA requester (no stall)
//   o_mem_addr    RAM word address ((addr - MEM_BASE) >> 2)
//   o_mem_wdata   RAM write data
//   o_mem_we      RAM write enable (RAM writes on the rising edge)
//   o_mem_re      RAM read enable
//   i_mem_rdata   combinational RAM read data
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE     = 32'h1001_0000,
  parameter int                    MEMORY_DEPTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,

  input  logic                  i_c_req,
  input  logic                  i_c_we,
  input  logic [ADDR_WIDTH-1:0] i_c_addr,
  input  logic [DATA_WIDTH-1:0] i_c_wdata,
  output logic                  o_c_ack,
  output logic [DATA_WIDTH-1:0] o_c_rdata,
  output logic                  o_c_err,
  output logic                  o_c_stall,

  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  output logic                  o_d_ack,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  output logic                  o_d_err,

  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  output logic                  o_mem_re,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Owner encoding, shared by the capture register and the round-robin pointer
  localparam logic OWNER_C = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // The legal window is evaluated one bit wider than the address bus, so a
  // RAM placed at the very top of the address space cannot wrap its upper
  // bound to a small number and accept every address.
  localparam logic [ADDR_WIDTH:0] LP_BASE_EXT = {1'b0, MEM_BASE};
  localparam logic [ADDR_WIDTH:0] LP_SPAN_EXT = (ADDR_WIDTH+1)'(4 * MEMORY_DEPTH);
  localparam logic [ADDR_WIDTH:0] LP_TOP_EXT  = LP_BASE_EXT + LP_SPAN_EXT;

  // FSM and captured-request registers
  logic [1:0]            r_state;
  logic                  r_we;
  logic                  r_owner;
  logic                  r_illegal;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_cRdata;
  logic [DATA_WIDTH-1:0] r_dRdata;

  // Combinational helpers
  logic [1:0]            w_nextState;
  logic                  w_anyReq;
  logic                  w_selD;
  logic                  w_capWe;
  logic [ADDR_WIDTH-1:0] w_capAddr;
  logic [DATA_WIDTH-1:0] w_capWdata;
  logic [ADDR_WIDTH:0]   w_capAddrExt;
  logic                  w_capIllegal;
  logic [ADDR_WIDTH-1:0] w_capWordOff;
  logic                  w_capture;
  logic                  w_inAccess;
  logic                  w_inDone;
  logic [DATA_WIDTH-1:0] w_loadData;

  assign w_anyReq   = i_c_req | i_d_req;
  assign w_inAccess = (r_state == ST_ACCESS);
  assign w_inDone   = (r_state == ST_DONE);
  assign w_capture  = (r_state == ST_IDLE) & w_anyReq;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Fixed priority: D is chosen only when C is not asking.
  always_comb begin
    w_selD = i_d_req & ~i_c_req;
  end
`else
  // Round-robin pointer: remembers who was captured most recently. It resets
  // to D so that C wins the very first tie.
  logic r_rrLast;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rrLast <= OWNER_D;
    end else if (w_capture) begin
      r_rrLast <= w_selD;
    end
  end

  // D wins when it is the only requester, or on a tie when C was served last.
  always_comb begin
    w_selD = i_d_req & (~i_c_req | (r_rrLast == OWNER_C));
  end
`endif

  // Request mux feeding the capture registers and the legality check
  always_comb begin
    w_capWe    = i_c_we;
    w_capAddr  = i_c_addr;
    w_capWdata = i_c_wdata;
    if (w_selD) begin
      w_capWe    = i_d_we;
      w_capAddr  = i_d_addr;
      w_capWdata = i_d_wdata;
    end
  end

  // Legality check: word alignment plus the RAM's byte window
  always_comb begin
    w_capAddrExt = {1'b0, w_capAddr};
    w_capIllegal = (w_capAddr[1:0] != 2'b00)
                 | (w_capAddrExt < LP_BASE_EXT)
                 | (w_capAddrExt >= LP_TOP_EXT);
    w_capWordOff = (w_capAddr - MEM_BASE) >> 2;
  end

  // Next-state logic: every captured request runs the full three states,
  // even if the requester drops its request along the way.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_anyReq) w_nextState = ST_ACCESS;
      ST_ACCESS: w_nextState = ST_DONE;
      ST_DONE:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Capture the winning request in IDLE. The word offset is stored rather
  // than the byte address, so the RAM address bus reads 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we      <= 1'b0;
      r_owner   <= OWNER_C;
      r_illegal <= 1'b0;
      r_memAddr <= '0;
      r_wdata   <= '0;
    end else if (w_capture) begin
      r_we      <= w_capWe;
      r_owner   <= w_selD;
      r_illegal <= w_capIllegal;
      r_memAddr <= w_capWordOff;
      r_wdata   <= w_capWdata;
    end
  end

  // Illegal accesses return zero, whether they were loads or stores.
  assign w_loadData = r_illegal ? '0 : i_mem_rdata;

  // Read-data registers, one per requester. They load at the end of ACCESS
  // for legal loads and for any illegal access, and otherwise hold, so a
  // legal store leaves the owner's previous read data visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cRdata <= '0;
      r_dRdata <= '0;
    end else if (w_inAccess && (!r_we || r_illegal)) begin
      if (r_owner == OWNER_D) begin
        r_dRdata <= w_loadData;
      end else begin
        r_cRdata <= w_loadData;
      end
    end
  end

  // RAM strobes come only from registered state. Because the state register
  // resets asynchronously, a reset during ACCESS drops the write enable at
  // once, and the aborted store never reaches the RAM.
  assign o_mem_we    = w_inAccess & r_we & ~r_illegal;
  assign o_mem_re    = w_inAccess & ~r_we & ~r_illegal;
  assign o_mem_addr  = r_memAddr;
  assign o_mem_wdata = r_wdata;

  // Completion signalling goes to the owner only.
  assign o_c_ack   = w_inDone & (r_owner == OWNER_C);
  assign o_d_ack   = w_inDone & (r_owner == OWNER_D);
  assign o_c_err   = o_c_ack & r_illegal;
  assign o_d_err   = o_d_ack & r_illegal;
  assign o_c_rdata = r_cRdata;
  assign o_d_rdata = r_dRdata;

  // The processor freezes from request until the cycle of its acknowledge.
  assign o_c_stall = i_c_req & ~o_c_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter with a behavioural 32-word RAM.
// A vector table holds the single accesses. Hand-written sequences cover
// contention, reset during an access, and an early request drop. Each
// acknowledge is checked against a queue of expected results.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk;
  logic        rstN;
  logic        cReq, cWe, dReq, dWe;
  logic [31:0] cAddr, cWdata, dAddr, dWdata;
  logic        cAck, cErr, cStall, dAck, dErr;
  logic [31:0] cRdata, dRdata;
  logic [31:0] memAddr, memWdata, memRdata;
  logic        memWe, memRe;
  logic        ramLoad;
  logic [31:0] ram [32];

  int nCompared;
  int nFailed;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expRdata;
    int          expMemCycles;
    logic [31:0] expMemAddr;
  } vec_t;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } sb_t;

  vec_t vecs[13];
  sb_t  sbQ[$];

  dmem_arbiter #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .MEM_BASE(BASE),
    .MEMORY_DEPTH(32)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_c_req(cReq),
    .i_c_we(cWe),
    .i_c_addr(cAddr),
    .i_c_wdata(cWdata),
    .o_c_ack(cAck),
    .o_c_rdata(cRdata),
    .o_c_err(cErr),
    .o_c_stall(cStall),
    .i_d_req(dReq),
    .i_d_we(dWe),
    .i_d_addr(dAddr),
    .i_d_wdata(dWdata),
    .o_d_ack(dAck),
    .o_d_rdata(dRdata),
    .o_d_err(dErr),
    .o_mem_addr(memAddr),
    .o_mem_wdata(memWdata),
    .o_mem_we(memWe),
    .o_mem_re(memRe),
    .i_mem_rdata(memRdata)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on contents of the RAM model: word 3 is DEADBEEF, the rest are tagged with their index
  function automatic logic [31:0] initWord(input int i);
    if (i == 3) return 32'hDEAD_BEEF;
    return {16'hC0DE, 16'(i)};
  endfunction

  // Behavioural RAM: rising-edge write, combinational read
  always @(posedge clk) begin
    if (ramLoad) begin
      for (int i = 0; i < 32; i++) ram[i] <= initWord(i);
    end else if (memWe) begin
      ram[memAddr[4:0]] <= memWdata;
    end
  end
  assign memRdata = ram[memAddr[4:0]];

  // Safety net in case a wait loop is ever broken
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at every sampling point. It checks the strobe invariant and
  // compares any acknowledge against the head of the expected queue.
  task automatic scoreboardCheck();
    sb_t e;
    checkOutput("strobesExclusive", 32'(memWe & memRe), 32'd0);
    if (cAck || dAck) begin
      checkOutput("singleAck", 32'(cAck & dAck), 32'd0);
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedAck", 32'(sbQ.size()), 32'd1);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sbOwner", 32'(dAck), 32'(e.port));
        checkOutput("sbErr", 32'(dAck ? dErr : cErr), 32'(e.err));
        checkOutput("sbRdata", dAck ? dRdata : cRdata, e.rdata);
      end
    end
  endtask

  task automatic pushExpected(input logic port, input logic err, input logic [31:0] rdata);
    sb_t e;
    e.port  = port;
    e.err   = err;
    e.rdata = rdata;
    sbQ.push_back(e);
  endtask

  task automatic dropReq(input logic port);
    if (port) dReq = 1'b0;
    else cReq = 1'b0;
  endtask

  // Entered and left at posedge+1. Waits for the owner's acknowledge and
  // checks latency, stall, and the RAM strobe activity along the way.
  task automatic waitAck(input logic port, input int expMemCycles, input logic [31:0] expMemAddr,
                         input logic [31:0] expWdata, input logic dropEarly, input string name);
    int memCycles;
    int ackCyc;
    logic acked;
    memCycles = 0;
    ackCyc = -1;
    acked = 1'b0;
    for (int cyc = 0; cyc < 16 && !acked; cyc++) begin
      @(negedge clk);
      scoreboardCheck();
      if (memWe || memRe) begin
        memCycles++;
        checkOutput({name, "_memAddr"}, memAddr, expMemAddr);
        if (memWe) checkOutput({name, "_memWdata"}, memWdata, expWdata);
      end
      if (!port && !dropEarly) checkOutput({name, "_stall"}, 32'(cStall), cAck ? 32'd0 : 32'd1);
      if ((!port && cAck) || (port && dAck)) begin
        acked = 1'b1;
        ackCyc = cyc;
      end
      if (dropEarly && cyc == 0) begin
        @(posedge clk);
        #1;
        dropReq(port);
      end
    end
    checkOutput({name, "_ackSeen"}, 32'(acked), 32'd1);
    checkOutput({name, "_latency"}, 32'(ackCyc), 32'd2);
    checkOutput({name, "_memCycles"}, 32'(memCycles), 32'(expMemCycles));
    @(posedge clk);
    #1;
    dropReq(port);
  endtask

  // Drives one request, records its expected result, and waits for it to complete.
  task automatic applyStimulus(input vec_t v, input logic dropEarly, input string name);
    if (v.port) begin
      dReq = 1'b1; dWe = v.we; dAddr = v.addr; dWdata = v.wdata;
    end else begin
      cReq = 1'b1; cWe = v.we; cAddr = v.addr; cWdata = v.wdata;
    end
    pushExpected(v.port, v.expErr, v.expRdata);
    waitAck(v.port, v.expMemCycles, v.expMemAddr, v.wdata, dropEarly, name);
  endtask

  // Idle cycles with no requests. Any acknowledge here is unexpected; memActive counts strobe cycles.
  task automatic idleCycles(input int n, output int memActive);
    memActive = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      scoreboardCheck();
      if (memWe || memRe) memActive++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int idleMem;
    vec_t v;
    nCompared = 0;
    nFailed   = 0;

    // port, we, addr, wdata, expErr, expRdata, expMemCycles, expMemAddr
    vecs[0]  = '{1'b0, 1'b0, BASE + 32'd12,  32'h0,         1'b0, 32'hDEAD_BEEF, 1, 32'd3};
    vecs[1]  = '{1'b1, 1'b1, BASE + 32'd4,   32'h0000_00A5, 1'b0, 32'h0,         1, 32'd1};
    vecs[2]  = '{1'b0, 1'b0, BASE + 32'd4,   32'h0,         1'b0, 32'h0000_00A5, 1, 32'd1};
    vecs[3]  = '{1'b0, 1'b1, BASE + 32'd20,  32'h1234_5678, 1'b0, 32'h0000_00A5, 1, 32'd5};
    vecs[4]  = '{1'b0, 1'b0, BASE + 32'd20,  32'h0,         1'b0, 32'h1234_5678, 1, 32'd5};
    vecs[5]  = '{1'b1, 1'b0, BASE + 32'd124, 32'h0,         1'b0, 32'hC0DE_001F, 1, 32'd31};
    vecs[6]  = '{1'b0, 1'b0, BASE + 32'd2,   32'h0,         1'b1, 32'h0,         0, 32'd0};
    vecs[7]  = '{1'b0, 1'b0, BASE + 32'd128, 32'h0,         1'b1, 32'h0,         0, 32'd0};
    vecs[8]  = '{1'b1, 1'b1, BASE - 32'd4,   32'hFFFF_FFFF, 1'b1, 32'h0,         0, 32'd0};
    vecs[9]  = '{1'b0, 1'b0, 32'hFFFF_FFFC,  32'h0,         1'b1, 32'h0,         0, 32'd0};
    vecs[10] = '{1'b1, 1'b0, BASE + 32'd20,  32'h0,         1'b0, 32'h1234_5678, 1, 32'd5};
    vecs[11] = '{1'b0, 1'b0, BASE + 32'd24,  32'h0,         1'b0, 32'hC0DE_0006, 1, 32'd6};
    vecs[12] = '{1'b0, 1'b1, BASE + 32'd126, 32'h5555_5555, 1'b1, 32'h0,         0, 32'd0};

    rstN = 1'b0; ramLoad = 1'b1;
    cReq = 1'b0; cWe = 1'b0; cAddr = '0; cWdata = '0;
    dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;
    @(posedge clk);
    #1;
    ramLoad = 1'b0;

    // Reset state: all outputs low
    @(negedge clk);
    checkOutput("rst_cAck", 32'(cAck), 32'd0);
    checkOutput("rst_dAck", 32'(dAck), 32'd0);
    checkOutput("rst_cErr", 32'(cErr), 32'd0);
    checkOutput("rst_dErr", 32'(dErr), 32'd0);
    checkOutput("rst_cStall", 32'(cStall), 32'd0);
    checkOutput("rst_cRdata", cRdata, 32'd0);
    checkOutput("rst_dRdata", dRdata, 32'd0);
    checkOutput("rst_memWe", 32'(memWe), 32'd0);
    checkOutput("rst_memRe", 32'(memRe), 32'd0);
    checkOutput("rst_memAddr", memAddr, 32'd0);
    checkOutput("rst_memWdata", memWdata, 32'd0);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Table of single accesses
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], 1'b0, $sformatf("vec%0d", i));
      idleCycles(1, idleMem);
    end
    checkOutput("ram_word5", ram[5], 32'h1234_5678);
    checkOutput("ram_word1", ram[1], 32'h0000_00A5);

    // Early drop: D's request is high for one cycle only, yet the access still completes, exactly once
    v = '{1'b1, 1'b0, BASE + 32'd12, 32'h0, 1'b0, 32'hDEAD_BEEF, 1, 32'd3};
    applyStimulus(v, 1'b1, "earlyDrop");
    idleCycles(6, idleMem);
    checkOutput("earlyDrop_noSecond", 32'(idleMem), 32'd0);

    // Reset pulled low during a store's ACCESS cycle
    cReq = 1'b1; cWe = 1'b1; cAddr = BASE + 32'd8; cWdata = 32'h0BAD_F00D;
    @(negedge clk);
    scoreboardCheck();
    checkOutput("rstMid_stallC0", 32'(cStall), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    scoreboardCheck();
    checkOutput("rstMid_weBefore", 32'(memWe), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rstMid_weDropped", 32'(memWe), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rstMid_ramKept", ram[2], 32'hC0DE_0002);
    @(negedge clk);
    scoreboardCheck();
    checkOutput("rstMid_noAck", 32'(cAck), 32'd0);
    checkOutput("rstMid_stallHeld", 32'(cStall), 32'd1);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    pushExpected(1'b0, 1'b0, 32'h0);
    waitAck(1'b0, 1, 32'd2, 32'h0BAD_F00D, 1'b0, "rstRetry");
    checkOutput("rstRetry_ram", ram[2], 32'h0BAD_F00D);
    idleCycles(1, idleMem);

    // Contention: both requests held high starting from reset
    rstN = 1'b0;
    cReq = 1'b1; cWe = 1'b0; cAddr = BASE + 32'd12;
    dReq = 1'b1; dWe = 1'b0; dAddr = BASE + 32'd4;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) pushExpected(1'b0, 1'b0, 32'hDEAD_BEEF);
`else
    for (int k = 0; k < 2; k++) begin
      pushExpected(1'b0, 1'b0, 32'hDEAD_BEEF);
      pushExpected(1'b1, 1'b0, 32'h0000_00A5);
    end
`endif
    @(posedge clk);
    #1;
    rstN = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      scoreboardCheck();
`ifdef DMEM_ARB_FIXED_PRIO_EN
      checkOutput($sformatf("cont_cAck_c%0d", cyc), 32'(cAck), 32'(cyc % 3 == 2));
      checkOutput($sformatf("cont_dAck_c%0d", cyc), 32'(dAck), 32'd0);
`else
      checkOutput($sformatf("cont_cAck_c%0d", cyc), 32'(cAck), 32'(cyc == 2 || cyc == 8));
      checkOutput($sformatf("cont_dAck_c%0d", cyc), 32'(dAck), 32'(cyc == 5 || cyc == 11));
`endif
    end
    @(posedge clk);
    #1;
    cReq = 1'b0;
    dReq = 1'b0;
    idleCycles(4, idleMem);
    checkOutput("cont_queueDrained", 32'(sbQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port data memory (RAM) between two requesters: the processor load/store path (port C) and a debug/DMA loader (port D).
- Sits between the processor datapath and the RAM instance.
- Captures one request at a time, sequences a fixed 3-state access, and returns registered read data with a one-cycle acknowledge.
- Drives a stall to the processor so the PC and register write-back freeze until the access completes.

Parameters:
- DATA_WIDTH, 32: width of all data buses.
- ADDR_WIDTH, 32: width of requester and memory addresses.
- MEM_BASE, 32'h1001_0000: byte address of RAM word 0.
- MEMORY_DEPTH, 32: RAM depth in words. Legal byte range is MEM_BASE .. MEM_BASE + 4*MEMORY_DEPTH - 1.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: Already decided — one clock; reset is asynchronous and active-low.
- c_req, input, 1: processor request; held high until c_ack.
- c_we, input, 1: processor store (1) or load (0).
- c_addr, input, ADDR_WIDTH: processor byte address.
- c_wdata, input, DATA_WIDTH: processor store data.
- c_ack, output, 1: one-cycle access-complete pulse.
- c_rdata, output, DATA_WIDTH: registered load data, valid while c_ack is high.
- c_err, output, 1: pulses with c_ack when the access was illegal.
- c_stall, output, 1: equals c_req & ~c_ack (combinational).
- d_req, d_we, d_addr, d_wdata, d_ack, d_rdata, d_err: same as the c_* ports, for the D requester.
- mem_addr, output, ADDR_WIDTH: word address offset, (addr - MEM_BASE) >> 2.
- mem_wdata, output, DATA_WIDTH: RAM write data.
- mem_we, output, 1: RAM write enable; the RAM writes on the rising edge.
- mem_re, output, 1: RAM read enable.
- mem_rdata, input, DATA_WIDTH: combinational RAM read data.

Behaviour:
- FSM states: IDLE, ACCESS, DONE.
- Reset values: state IDLE, rr_last = D (so C wins the first tie), captured registers 0, all outputs 0.
- IDLE: if any req is high, select the winner, capture we/addr/wdata/owner, and go to ACCESS. Otherwise stay in IDLE.
- Winner selection:
  - Only one req high: that requester wins.
  - Both high: round-robin; the requester that was not served last (rr_last) wins.
  - rr_last updates on capture.
- Legality check on capture: the access is illegal if addr[1:0] != 0 or addr is outside the legal range. Illegal is computed with ADDR_WIDTH+1-bit arithmetic so that no wrap-around occurs at the top of the address space.
- ACCESS, legal access:
  - mem_re = ~we and mem_we = we, both driven from registered state.
  - mem_addr and mem_wdata come from the captured values.
  - For a load, mem_rdata is registered into the owner's rdata at the end of this cycle.
  - Next state is DONE.
- ACCESS, illegal access: mem_re and mem_we stay 0, rdata is registered as 0, next state is DONE.
- DONE:
  - Owner's ack = 1; owner's err = illegal flag.
  - Non-owner's ack and err stay 0.
  - Next state is IDLE.
- Latency: req seen in cycle N gives ack in cycle N+2. Maximum throughput is one access per 3 cycles.
- Worst-case wait for a requester holding req while the other is also requesting: 6 cycles.
- A requester that deasserts req before its ack: the captured access still completes and the ack still pulses. A new request is seen only in IDLE.
- rdata holds its last value after ack. For a store, rdata is unchanged.
- mem_we and mem_re are 0 in IDLE and DONE, and are never both high.
- Reset asserted mid-ACCESS: mem_we drops immediately (asynchronous path through state), no write occurs, no ack is issued, FSM returns to IDLE.
- c_stall is combinational from c_req and c_ack: high from request through the cycle before ack, low in the ack cycle.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: C always wins simultaneous requests; rr_last is not implemented; D can be starved indefinitely.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Single C load: RAM word 3 = 32'hDEAD_BEEF; c_req=1, c_we=0, c_addr=MEM_BASE+12 at cycle 0 -> mem_re=1, mem_addr=3 in cycle 1; c_ack=1, c_rdata=32'hDEAD_BEEF, c_err=0 in cycle 2; c_stall high in cycles 0-1, low in cycle 2.
- Single D store: d_we=1, d_addr=MEM_BASE+4, d_wdata=32'h0000_00A5 -> mem_we=1 for exactly one cycle with mem_addr=1; d_ack in cycle 2; a later C load of MEM_BASE+4 returns 32'h0000_00A5.
- Contention: c_req and d_req held high from reset -> grants in order C, D, C, D; acks at cycles 2, 5, 8, 11. With DMEM_ARB_FIXED_PRIO_EN defined -> only C is acked while c_req stays high.
- Illegal addresses: c_addr=MEM_BASE+2 or MEM_BASE+128 with MEMORY_DEPTH=32 -> c_ack=1, c_err=1, c_rdata=0; mem_we and mem_re never assert.
- Reset mid-access: store captured, reset pulled low during ACCESS -> mem_we=0 immediately, RAM word unchanged, c_ack never pulses; after reset release with c_req still high -> normal 3-cycle access.
- Early req drop: d_req high for cycle 0 only -> d_ack still pulses in cycle 2; no second access is started.
